control_unit: RTL and testbench

Hardwired control sequencer for the single-bus datapath. It drives every datapath control strobe (register select, bus-out, latch-enable, memory read/write, ALU opcode) that benches currently drive by hand. Per instruction it runs the fetch steps T0-T2, then an opcode-specific execute sequence of up to five steps, T3-T7. It sits beside `datapath`: it takes `IR` and `CON_FF` from it and feeds back all control inputs.

---
 rtl/control_unit.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving every datapath strobe from state + latched opcode.
// Latency: one state per clock; instructions take 4-8 cycles including the three fetch steps.
// Backpressure: none; Stop is honoured only at instruction boundaries and parks the unit in HALT.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    output logic        read,
    output logic        write,
    output logic        BAout,
    output logic        Rin,
    output logic        Rout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        CONN_in,
    output logic        MARin,
    output logic        MDRin,
    output logic        HIin,
    output logic        LOin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        IRin,
    output logic        incPC,
    output logic        InPortIn,
    output logic        OutPortIn,
    output logic        HIout,
    output logic        LOout,
    output logic        ZHighOut,
    output logic        ZLowOut,
    output logic        MDRout,
    output logic        PCout,
    output logic        InPortOut,
    output logic        Cout,
    output logic [4:0]  opcode
);

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef struct packed {
        logic       read, write, ba_out, r_in, r_out, gra, grb, grc, conn_in;
        logic       mar_in, mdr_in, hi_in, lo_in, y_in, z_in, pc_in, ir_in, inc_pc;
        logic       inport_in, outport_in;
        logic       hi_out, lo_out, zhi_out, zlo_out, mdr_out, pc_out, inport_out, c_out;
        logic [4:0] alu_op;
    } ctrl_t;

    localparam logic [4:0] I_LD   = 5'b00000, I_LDI  = 5'b00001, I_ST   = 5'b00010;
    localparam logic [4:0] I_ADD  = 5'b00011, I_SUB  = 5'b00100, I_AND  = 5'b00101;
    localparam logic [4:0] I_OR   = 5'b00110, I_SHR  = 5'b00111, I_SHRA = 5'b01000;
    localparam logic [4:0] I_SHL  = 5'b01001, I_ROR  = 5'b01010, I_ROL  = 5'b01011;
    localparam logic [4:0] I_ADDI = 5'b01100, I_ANDI = 5'b01101, I_ORI  = 5'b01110;
    localparam logic [4:0] I_MUL  = 5'b01111, I_DIV  = 5'b10000, I_NEG  = 5'b10001;
    localparam logic [4:0] I_NOT  = 5'b10010, I_BR   = 5'b10011, I_JR   = 5'b10100;
    localparam logic [4:0] I_IN   = 5'b10110, I_OUT  = 5'b10111, I_MFHI = 5'b11000;
    localparam logic [4:0] I_MFLO = 5'b11001, I_HALT = 5'b11011;

    localparam logic [4:0] ALU_NOP  = 5'b00000, ALU_ADD = 5'b00001, ALU_SUB = 5'b00010;
    localparam logic [4:0] ALU_MUL  = 5'b00011, ALU_DIV = 5'b00100, ALU_SHR = 5'b00101;
    localparam logic [4:0] ALU_SHL  = 5'b00110, ALU_SHRA = 5'b00111, ALU_ROR = 5'b01000;
    localparam logic [4:0] ALU_ROL  = 5'b01001, ALU_AND = 5'b01010, ALU_OR  = 5'b01011;
    localparam logic [4:0] ALU_NEG  = 5'b01100, ALU_NOT = 5'b01111;

    state_t     state_q, state_d;
    logic [4:0] op_q;
    ctrl_t      ctrl;
    logic       run;
    logic       is_imm;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];
    assign is_imm    = (op_q == I_ADDI) || (op_q == I_ANDI) || (op_q == I_ORI);

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        case (op)
            I_ADD, I_ADDI: alu_of = ALU_ADD;
            I_SUB:         alu_of = ALU_SUB;
            I_AND, I_ANDI: alu_of = ALU_AND;
            I_OR, I_ORI:   alu_of = ALU_OR;
            I_SHR:         alu_of = ALU_SHR;
            I_SHRA:        alu_of = ALU_SHRA;
            I_SHL:         alu_of = ALU_SHL;
            I_ROR:         alu_of = ALU_ROR;
            I_ROL:         alu_of = ALU_ROL;
            I_MUL:         alu_of = ALU_MUL;
            I_DIV:         alu_of = ALU_DIV;
            I_NEG:         alu_of = ALU_NEG;
            I_NOT:         alu_of = ALU_NOT;
            default:       alu_of = ALU_NOP;
        endcase
    endfunction

    // Final execute step per instruction; unlisted codes behave as nop (T3 only).
    function automatic state_t last_step(input logic [4:0] op);
        case (op)
            I_ADD, I_SUB, I_AND, I_OR, I_SHR, I_SHRA, I_SHL, I_ROR, I_ROL,
            I_ADDI, I_ANDI, I_ORI, I_LDI:  last_step = ST_T5;
            I_NEG, I_NOT:                  last_step = ST_T4;
            I_MUL, I_DIV, I_BR:            last_step = ST_T6;
            I_LD, I_ST:                    last_step = ST_T7;
            default:                       last_step = ST_T3;
        endcase
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q <= 5'b00000;
        end else if (state_q == ST_T2) begin
            op_q <= IR[31:27];
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        run     = 1'b1;
        case (state_q)
            ST_RESET: state_d = Stop ? ST_HALT : ST_T0;
            ST_T0: begin
                state_d      = ST_T1;
                ctrl.pc_out  = 1'b1;
                ctrl.mar_in  = 1'b1;
                ctrl.inc_pc  = 1'b1;
                ctrl.z_in    = 1'b1;
            end
            ST_T1: begin
                state_d      = ST_T2;
                ctrl.zlo_out = 1'b1;
                ctrl.pc_in   = 1'b1;
                ctrl.read    = 1'b1;
                ctrl.mdr_in  = 1'b1;
            end
            ST_T2: begin
                state_d      = ST_T3;
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_HALT: run = 1'b0;
            default: begin
                if (state_q == last_step(op_q)) begin
                    state_d = (op_q == I_HALT || Stop) ? ST_HALT : ST_T0;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
                case (op_q)
                    I_ADD, I_SUB, I_AND, I_OR, I_SHR, I_SHRA, I_SHL, I_ROR, I_ROL,
                    I_ADDI, I_ANDI, I_ORI: begin
                        case (state_q)
                            ST_T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                            ST_T4: begin
                                if (is_imm) begin
                                    ctrl.c_out = 1'b1;
                                end else begin
                                    ctrl.grc   = 1'b1;
                                    ctrl.r_out = 1'b1;
                                end
                                ctrl.alu_op = alu_of(op_q);
                                ctrl.z_in   = 1'b1;
                            end
                            ST_T5: begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    I_NEG, I_NOT: begin
                        case (state_q)
                            ST_T3: begin
                                ctrl.grb    = 1'b1;
                                ctrl.r_out  = 1'b1;
                                ctrl.alu_op = alu_of(op_q);
                                ctrl.z_in   = 1'b1;
                            end
                            ST_T4: begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    I_MUL, I_DIV: begin
                        case (state_q)
                            ST_T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                            ST_T4: begin
                                ctrl.grb    = 1'b1;
                                ctrl.r_out  = 1'b1;
                                ctrl.alu_op = alu_of(op_q);
                                ctrl.z_in   = 1'b1;
                            end
                            ST_T5: begin ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1; end
                            ST_T6: begin ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    // Loads and stores share the base+offset address computation in T3-T4.
                    I_LD, I_LDI, I_ST: begin
                        case (state_q)
                            ST_T3: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                            ST_T4: begin ctrl.c_out = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.z_in = 1'b1; end
                            ST_T5: begin
                                ctrl.zlo_out = 1'b1;
                                if (op_q == I_LDI) begin
                                    ctrl.gra  = 1'b1;
                                    ctrl.r_in = 1'b1;
                                end else begin
                                    ctrl.mar_in = 1'b1;
                                end
                            end
                            ST_T6: begin
                                ctrl.mdr_in = 1'b1;
                                if (op_q == I_ST) begin
                                    ctrl.gra   = 1'b1;
                                    ctrl.r_out = 1'b1;
                                end else begin
                                    ctrl.read = 1'b1;
                                end
                            end
                            ST_T7: begin
                                if (op_q == I_ST) begin
                                    ctrl.write = 1'b1;
                                end else begin
                                    ctrl.mdr_out = 1'b1;
                                    ctrl.gra     = 1'b1;
                                    ctrl.r_in    = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    I_BR: begin
                        case (state_q)
                            ST_T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.conn_in = 1'b1; end
                            ST_T4: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                            ST_T5: begin ctrl.c_out = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.z_in = 1'b1; end
                            ST_T6: begin ctrl.zlo_out = CON_FF; ctrl.pc_in = CON_FF; end
                            default: ;
                        endcase
                    end
                    I_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                    I_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    I_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
                    I_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    I_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    default: ;
                endcase
            end
        endcase
    end

    assign Run       = run;
    assign read      = ctrl.read;
    assign write     = ctrl.write;
    assign BAout     = ctrl.ba_out;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign CONN_in   = ctrl.conn_in;
    assign MARin     = ctrl.mar_in;
    assign MDRin     = ctrl.mdr_in;
    assign HIin      = ctrl.hi_in;
    assign LOin      = ctrl.lo_in;
    assign Yin       = ctrl.y_in;
    assign Zin       = ctrl.z_in;
    assign PCin      = ctrl.pc_in;
    assign IRin      = ctrl.ir_in;
    assign incPC     = ctrl.inc_pc;
    assign InPortIn  = ctrl.inport_in;
    assign OutPortIn = ctrl.outport_in;
    assign HIout     = ctrl.hi_out;
    assign LOout     = ctrl.lo_out;
    assign ZHighOut  = ctrl.zhi_out;
    assign ZLowOut   = ctrl.zlo_out;
    assign MDRout    = ctrl.mdr_out;
    assign PCout     = ctrl.pc_out;
    assign InPortOut = ctrl.inport_out;
    assign Cout      = ctrl.c_out;
    assign opcode    = ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: expected per-cycle strobe words come from named micro-step lists.
// Latency: one compared word per clock while an expectation is queued.
// Backpressure: none; the driver paces instructions by their expected step count.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr, CON_FF, Stop;
    logic [31:0] IR;
    logic        Run, read, write, BAout, Rin, Rout, Gra, Grb, Grc, CONN_in;
    logic        MARin, MDRin, HIin, LOin, Yin, Zin, PCin, IRin, incPC, InPortIn, OutPortIn;
    logic        HIout, LOout, ZHighOut, ZLowOut, MDRout, PCout, InPortOut, Cout;
    logic [4:0]  opcode;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
        .read(read), .write(write), .BAout(BAout), .Rin(Rin), .Rout(Rout), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .CONN_in(CONN_in), .MARin(MARin), .MDRin(MDRin),
        .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
        .incPC(incPC), .InPortIn(InPortIn), .OutPortIn(OutPortIn), .HIout(HIout),
        .LOout(LOout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut), .MDRout(MDRout),
        .PCout(PCout), .InPortOut(InPortOut), .Cout(Cout), .opcode(opcode)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    logic [33:0] exp_q[$];
    logic [33:0] hist[$];
    logic [33:0] prog[$];
    logic [33:0] e_cur;
    logic [33:0] obs;

    string names[28] = '{"read", "write", "BAout", "Rin", "Rout", "Gra", "Grb", "Grc",
                         "CONN_in", "MARin", "MDRin", "HIin", "LOin", "Yin", "Zin", "PCin",
                         "IRin", "incPC", "InPortIn", "OutPortIn", "HIout", "LOout",
                         "ZHighOut", "ZLowOut", "MDRout", "PCout", "InPortOut", "Cout"};

    assign obs = {Run, Cout, InPortOut, PCout, MDRout, ZLowOut, ZHighOut, LOout, HIout,
                  OutPortIn, InPortIn, incPC, IRin, PCin, Zin, Yin, LOin, HIin, MDRin,
                  MARin, CONN_in, Grc, Grb, Gra, Rout, Rin, BAout, write, read, opcode};

    // Word = {Run, strobe k at bit 5+k, ALU opcode}, built from a space-separated name list.
    function automatic logic [33:0] w(input string s, input logic [4:0] op = 5'b0,
                                      input bit run = 1'b1);
        logic [33:0] v;
        int          st;
        string       tok;
        bit          found;
        v = '0;
        v[33] = run;
        v[4:0] = op;
        st = 0;
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s.getc(i) == 8'h20) begin
                if (i > st) begin
                    tok = s.substr(st, i - 1);
                    found = 1'b0;
                    for (int k = 0; k < 28; k++) begin
                        if (names[k] == tok) begin
                            v[5 + k] = 1'b1;
                            found = 1'b1;
                        end
                    end
                    if (!found) begin
                        errors++;
                        $display("FAIL model_token: got '%s', required a known strobe name", tok);
                    end
                end
                st = i + 1;
            end
        end
        return v;
    endfunction

    function automatic logic [4:0] alu_for(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return 5'b00001;
            5'd4:        return 5'b00010;
            5'd5, 5'd13: return 5'b01010;
            5'd6, 5'd14: return 5'b01011;
            5'd7:        return 5'b00101;
            5'd8:        return 5'b00111;
            5'd9:        return 5'b00110;
            5'd10:       return 5'b01000;
            5'd11:       return 5'b01001;
            5'd15:       return 5'b00011;
            5'd16:       return 5'b00100;
            5'd17:       return 5'b01100;
            5'd18:       return 5'b01111;
            default:     return 5'b00000;
        endcase
    endfunction

    function automatic void build(input logic [4:0] op, input bit cf);
        logic [4:0] a;
        a = alu_for(op);
        prog.delete();
        prog.push_back(w("PCout MARin incPC Zin"));
        prog.push_back(w("ZLowOut PCin read MDRin"));
        prog.push_back(w("MDRout IRin"));
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                prog.push_back(w("Grb Rout Yin"));
                prog.push_back(w("Grc Rout Zin", a));
                prog.push_back(w("ZLowOut Gra Rin"));
            end
            5'd12, 5'd13, 5'd14: begin
                prog.push_back(w("Grb Rout Yin"));
                prog.push_back(w("Cout Zin", a));
                prog.push_back(w("ZLowOut Gra Rin"));
            end
            5'd15, 5'd16: begin
                prog.push_back(w("Gra Rout Yin"));
                prog.push_back(w("Grb Rout Zin", a));
                prog.push_back(w("ZLowOut LOin"));
                prog.push_back(w("ZHighOut HIin"));
            end
            5'd17, 5'd18: begin
                prog.push_back(w("Grb Rout Zin", a));
                prog.push_back(w("ZLowOut Gra Rin"));
            end
            5'd0, 5'd1, 5'd2: begin
                prog.push_back(w("Grb BAout Yin"));
                prog.push_back(w("Cout Zin", 5'b00001));
                if (op == 5'd1) begin
                    prog.push_back(w("ZLowOut Gra Rin"));
                end else begin
                    prog.push_back(w("ZLowOut MARin"));
                    if (op == 5'd0) begin
                        prog.push_back(w("read MDRin"));
                        prog.push_back(w("MDRout Gra Rin"));
                    end else begin
                        prog.push_back(w("Gra Rout MDRin"));
                        prog.push_back(w("write"));
                    end
                end
            end
            5'd19: begin
                prog.push_back(w("Gra Rout CONN_in"));
                prog.push_back(w("PCout Yin"));
                prog.push_back(w("Cout Zin", 5'b00001));
                prog.push_back(cf ? w("ZLowOut PCin") : w(""));
            end
            5'd20:   prog.push_back(w("Gra Rout PCin"));
            5'd22:   prog.push_back(w("InPortOut Gra Rin"));
            5'd23:   prog.push_back(w("Gra Rout OutPortIn"));
            5'd24:   prog.push_back(w("HIout Gra Rin"));
            5'd25:   prog.push_back(w("LOout Gra Rin"));
            default: prog.push_back(w(""));
        endcase
    endfunction

    function automatic bit fb(input logic [33:0] v, input string n);
        for (int k = 0; k < 28; k++) begin
            if (names[k] == n) return v[5 + k];
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        hist.push_back(obs);
        if (exp_q.size() != 0) begin
            e_cur = exp_q.pop_front();
            vectors++;
            if (obs !== e_cur) begin
                errors++;
                $display("FAIL step_word t=%0t: got %h, required %h", $time, obs, e_cur);
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        clr = 1'b0;
        Stop = 1'b0;
        exp_q.push_back(w(""));
        #1;
        chk("reset_run", 64'(Run), 64'h1);
        chk("reset_opcode", 64'(opcode), 64'h0);
        repeat (n - 1) begin
            @(posedge clk); #1;
            exp_q.push_back(w(""));
        end
        @(posedge clk); #1;
        exp_q.push_back(w(""));
        clr = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n, input logic [33:0] word);
        repeat (n) begin
            @(posedge clk); #1;
            exp_q.push_back(word);
        end
        @(negedge clk); #1;
    endtask

    // Called just before the edge that enters T0; abort >= 0 pulses clr in that step.
    task automatic run_instr(input logic [31:0] ir, input bit cf, input bit stop,
                             input int abort, output int start);
        int n;
        build(ir[31:27], cf);
        n = prog.size();
        start = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                IR = ir;
                CON_FF = cf;
                Stop = 1'b0;
                start = hist.size();
            end
            exp_q.push_back(prog[i]);
            if (i == n - 1) Stop = stop;
            if (i == abort) begin
                @(negedge clk); #1;
                clr = 1'b0;
                #1;
                chk("async_clear", 64'(obs), 64'(w("")));
                @(posedge clk); #1;
                exp_q.push_back(w(""));
                clr = 1'b1;
                @(negedge clk); #1;
                return;
            end
        end
        @(negedge clk); #1;
    endtask

    logic [4:0]  tbl [0:23] = '{5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                5'd13, 5'd14, 5'd16, 5'd17, 5'd18, 5'd20, 5'd21, 5'd22,
                                5'd23, 5'd24, 5'd25, 5'd26, 5'd28, 5'd31};
    logic [33:0] h;
    logic [7:0]  m;
    int          s;

    initial begin
        clr = 1'b0;
        IR = 32'h0;
        CON_FF = 1'b0;
        Stop = 1'b0;
        do_reset(3);

        run_instr(32'h611BFFFD, 1'b0, 1'b0, -1, s);
        h = hist[s];
        chk("t0_after_reset", 64'({fb(h, "PCout"), fb(h, "MARin"), fb(h, "incPC"), fb(h, "Zin")}), 64'hF);
        chk("addi_len", 64'(prog.size()), 64'd6);
        h = hist[s + 3];
        chk("addi_t3", 64'({fb(h, "Grb"), fb(h, "Rout"), fb(h, "Yin")}), 64'h7);
        h = hist[s + 4];
        chk("addi_t4_op", 64'(h[4:0]), 64'h1);
        chk("addi_t4_cout", 64'({fb(h, "Cout"), fb(h, "Zin"), fb(h, "Grc")}), 64'h6);

        run_instr(32'h00800054, 1'b0, 1'b0, -1, s);
        chk("ld_len", 64'(prog.size()), 64'd8);
        m = '0;
        for (int i = 0; i < 8; i++) m[i] = fb(hist[s + i], "read");
        chk("ld_read_mask", 64'(m), 64'h42);
        h = hist[s + 7];
        chk("ld_t7", 64'({fb(h, "MDRout"), fb(h, "Gra"), fb(h, "Rin")}), 64'h7);

        run_instr(32'h98000000, 1'b0, 1'b0, -1, s);
        chk("br_len", 64'(prog.size()), 64'd7);
        h = hist[s + 6];
        chk("br0_t6", 64'({fb(h, "ZLowOut"), fb(h, "PCin")}), 64'h0);
        run_instr(32'h98000000, 1'b1, 1'b0, -1, s);
        h = hist[s + 6];
        chk("br1_t6", 64'({fb(h, "ZLowOut"), fb(h, "PCin")}), 64'h3);

        run_instr(32'h79880000, 1'b0, 1'b0, -1, s);
        chk("mul_t4_op", 64'(hist[s + 4][4:0]), 64'h3);
        chk("mul_t5_loin", 64'(fb(hist[s + 5], "LOin")), 64'h1);
        h = hist[s + 6];
        chk("mul_t6", 64'({fb(h, "ZHighOut"), fb(h, "HIin")}), 64'h3);

        for (int i = 0; i < 24; i++) begin
            run_instr({tbl[i], 27'($urandom)}, 1'($urandom), 1'b0, -1, s);
        end

        run_instr(32'hD8000000, 1'b0, 1'b0, -1, s);
        chk("halt_len", 64'(prog.size()), 64'd4);
        idle(10, w("", 5'b0, 1'b0));
        chk("halt_run", 64'(hist[hist.size() - 1][33]), 64'h0);

        do_reset(3);
        run_instr(32'h18A40000, 1'b0, 1'b1, -1, s);
        idle(3, w("", 5'b0, 1'b0));
        chk("stop_run", 64'(Run), 64'h0);

        do_reset(2);
        run_instr(32'h00800054, 1'b0, 1'b0, 5, s);
        run_instr(32'h611BFFFD, 1'b0, 1'b0, -1, s);
        h = hist[s];
        chk("t0_after_abort", 64'({fb(h, "PCout"), fb(h, "MARin"), fb(h, "incPC"), fb(h, "Zin")}), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required finish earlier");
        $fatal(1);
    end

endmodule
